ro_freq_counter: RTL

Measurement stage directly downstream of the ring oscillator. It enables the oscillator, synchronizes its free-running asynchronous output into the system clock domain, and counts rising edges over a fixed gate window. It reports the count with a one-cycle done pulse. Sits between the oscillator's en/out pins and any host logic that reads oscillator frequency.

---
 rtl/ro_freq_counter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter: enables the oscillator, synchronizes its output
// and counts rising edges over a fixed gate window, reporting the result with a done pulse.
`timescale 1ns/1ps
module ro_freq_counter #(
    parameter int GATE_CYCLES = 1000,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ro_in,
    output logic             ro_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    localparam int GATE_W = $clog2(GATE_CYCLES + 1);
    localparam int WARM_W = $clog2(SYNC_STAGES + 2);
    // One timer serves both phases, so it must be wide enough for the warm-up reload too.
    localparam int TMR_W  = (GATE_W > WARM_W) ? GATE_W : WARM_W;

    localparam logic [TMR_W-1:0] WARM_LOAD = TMR_W'(SYNC_STAGES);
    localparam logic [TMR_W-1:0] GATE_LOAD = TMR_W'(GATE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
    localparam logic [TMR_W-1:0] TMR_ZERO  = TMR_W'(0);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WARMUP  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   ovf_q, ovf_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   ro_en_q, ro_en_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   rise_s;

    // Synchronizer shift and rising-edge detection on the synchronized sample.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], ro_in};
        prev_d = sync_q[SYNC_STAGES-1];
        rise_s = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    // Next-state, gate timer and saturating edge counter.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_WARMUP;
                    timer_d = WARM_LOAD;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WARMUP: begin
                if (timer_q == TMR_ZERO) begin
                    state_d = ST_MEASURE;
                    timer_d = GATE_LOAD;
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end
            ST_MEASURE: begin
                if (rise_s) begin
                    if (count_q == CNT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + CNT_ONE;
                    end
                end else begin
                    count_d = count_q;
                end
                if (timer_q == TMR_ZERO) begin
                    state_d = ST_DONE;
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered, decoded from the state being entered.
    always_comb begin
        ro_en_d = (state_d == ST_WARMUP) || (state_d == ST_MEASURE);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            sync_q  <= '0;
            prev_q  <= 1'b0;
            ro_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            ro_en_q <= ro_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign ro_en = ro_en_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign count = count_q;
    assign ovf   = ovf_q;

endmodule
